// File: rtl/control_seq.sv
// Multi-cycle RV32 control sequencer: beat-wise fetch and load/store, single-cycle
// decode, bus timeout, illegal-opcode trap and debug halt/step/resume.
module control_seq #(
    parameter int BUS_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 15,
    localparam int BEATS = 32 / BUS_WIDTH,
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    opcode,
    input  logic [2:0]    f3,
    input  logic          mem_complete,
    input  logic          exception,
    input  logic          halt_req,
    input  logic          resume_req,
    input  logic          step_req,
    output logic          write_ir,
    output logic          write_pc,
    output logic          write_pc_ex,
    output logic          write_rd,
    output logic          write_csr,
    output logic          mem_read,
    output logic          mem_write,
    output logic          load_op,
    output logic          addr_sel,
    output logic [1:0]    rd_sel,
    output logic [1:0]    alu_insel1,
    output logic [1:0]    alu_insel2,
    output logic [BW-1:0] beat_idx,
    output logic          halted,
    output logic          bus_timeout,
    output logic          illegal_op
);

    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(MEM_TIMEOUT);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic       ADDR_PC  = 1'b0;
    localparam logic       ADDR_ALU = 1'b1;
    localparam logic [1:0] RD_ALU   = 2'd0;
    localparam logic [1:0] RD_MEM   = 2'd1;
    localparam logic [1:0] RD_CSR   = 2'd2;
    localparam logic [1:0] IN1_RS   = 2'd0;
    localparam logic [1:0] IN1_PC   = 2'd1;
    localparam logic [1:0] IN1_ZR   = 2'd2;
    localparam logic [1:0] IN2_RS   = 2'd0;
    localparam logic [1:0] IN2_IM   = 2'd1;
    localparam logic [1:0] IN2_IS   = 2'd2;

    typedef enum logic [2:0] {
        FETCH, DISPATCH, MEM, LOAD_WB, STORE_DONE, HALTED
    } state_t;

    state_t        state, next_state;
    logic [TW-1:0] tmo_cnt;
    logic          halt_pend;
    logic          step_arm;
    logic          is_store;
    logic          write_pc_ne;
    logic          boundary;
    logic          beat_adv;
    logic          exc;

    // Memory handshake: mem_read/mem_write hold the request for the current beat;
    // mem_complete ends that beat and is consumed only in FETCH or MEM.
    always_comb begin
        next_state  = state;
        write_ir    = 1'b0;
        write_pc_ne = 1'b0;
        write_pc_ex = 1'b0;
        write_rd    = 1'b0;
        write_csr   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        load_op     = 1'b0;
        addr_sel    = ADDR_PC;
        rd_sel      = RD_ALU;
        alu_insel1  = IN1_RS;
        alu_insel2  = IN2_RS;
        halted      = 1'b0;
        bus_timeout = 1'b0;
        illegal_op  = 1'b0;
        boundary    = 1'b0;
        beat_adv    = 1'b0;
        exc         = 1'b0;
        if (rst) begin
            mem_read = 1'b1;
        end else begin
            beat_adv = mem_complete && (state == FETCH || state == MEM);
            if (MEM_TIMEOUT != 0)
                bus_timeout = (state == FETCH || state == MEM) && !mem_complete &&
                              (tmo_cnt == TMO_LIMIT);
            case (state)
                FETCH: begin
                    mem_read = 1'b1;
                    addr_sel = ADDR_PC;
                    if (mem_complete && beat_idx == LAST_BEAT) begin
                        write_ir   = 1'b1;
                        next_state = DISPATCH;
                    end
                end
                DISPATCH: begin
                    case (opcode)
                        OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: begin
                            write_rd    = 1'b1;
                            write_pc_ne = 1'b1;
                            boundary    = 1'b1;
                            case (opcode)
                                OPC_LUI:    begin alu_insel1 = IN1_ZR; alu_insel2 = IN2_IM; end
                                OPC_AUIPC:  begin alu_insel1 = IN1_PC; alu_insel2 = IN2_IM; end
                                OPC_OP_IMM: begin alu_insel1 = IN1_RS; alu_insel2 = IN2_IM; end
                                OPC_OP:     begin alu_insel1 = IN1_RS; alu_insel2 = IN2_RS; end
                                default:    begin alu_insel1 = IN1_PC; alu_insel2 = IN2_IS; end
                            endcase
                        end
                        OPC_BRANCH, OPC_MISC_MEM: begin
                            write_pc_ne = 1'b1;
                            boundary    = 1'b1;
                        end
                        OPC_SYSTEM: begin
                            write_pc_ne = 1'b1;
                            boundary    = 1'b1;
                            if (f3 != 3'd0) begin
                                rd_sel    = RD_CSR;
                                write_rd  = 1'b1;
                                write_csr = 1'b1;
                            end
                        end
                        OPC_LOAD, OPC_STORE: next_state = MEM;
                        default:             illegal_op = 1'b1;
                    endcase
                end
                MEM: begin
                    addr_sel   = ADDR_ALU;
                    alu_insel1 = IN1_RS;
                    alu_insel2 = IN2_IM;
                    if (is_store) mem_write = 1'b1;
                    else          mem_read  = 1'b1;
                    if (mem_complete && beat_idx == LAST_BEAT)
                        next_state = is_store ? STORE_DONE : LOAD_WB;
                end
                LOAD_WB: begin
                    load_op     = 1'b1;
                    rd_sel      = RD_MEM;
                    write_rd    = 1'b1;
                    write_pc_ne = 1'b1;
                    boundary    = 1'b1;
                end
                STORE_DONE: begin
                    write_pc_ne = 1'b1;
                    boundary    = 1'b1;
                end
                HALTED: begin
                    halted = 1'b1;
                    if (resume_req || step_req) next_state = FETCH;
                end
                default: next_state = FETCH;
            endcase
            // A trap squashes architectural writes and redirects; it is also an
            // instruction boundary, so a pending halt or step is honoured here.
            exc = (state != HALTED) && (exception || illegal_op || bus_timeout);
            if (exc) begin
                write_rd    = 1'b0;
                write_csr   = 1'b0;
                mem_write   = 1'b0;
                write_pc_ex = 1'b1;
                boundary    = 1'b1;
            end
            if (boundary)
                next_state = (halt_pend || halt_req || step_arm) ? HALTED : FETCH;
        end
        write_pc = write_pc_ne | write_pc_ex;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            beat_idx  <= '0;
            tmo_cnt   <= '0;
            halt_pend <= 1'b0;
            step_arm  <= 1'b0;
            is_store  <= 1'b0;
        end else begin
            state <= next_state;

            if (exc || next_state != state) beat_idx <= '0;
            else if (beat_adv)              beat_idx <= beat_idx + BW'(1);

            if (exc || beat_adv || next_state != state)
                tmo_cnt <= '0;
            else if (MEM_TIMEOUT != 0 && (state == FETCH || state == MEM))
                tmo_cnt <= tmo_cnt + TW'(1);

            if (next_state == HALTED)                 halt_pend <= 1'b0;
            else if (state != HALTED && halt_req)     halt_pend <= 1'b1;

            // Step leaves HALTED with a re-halt armed for the next boundary.
            if (state == HALTED && step_req && !resume_req) step_arm <= 1'b1;
            else if (next_state == HALTED)                  step_arm <= 1'b0;

            if (state == DISPATCH) is_store <= (opcode == OPC_STORE);
        end
    end

endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter BUS_WIDTH, default 32, SHALL give the memory data width; legal values are 8, 16 and 32. BEATS SHALL equal 32/BUS_WIDTH.
REQ-003 Parameter MEM_TIMEOUT, default 15, SHALL give the number of wait cycles allowed per memory beat; a value of 0 disables the timeout.
REQ-004 The ports SHALL be as follows:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- opcode  in  5  instruction opcode field (instr[6:2])
- f3  in  3  funct3 field
- mem_complete  in  1  current memory beat finished
- exception  in  1  external exception this cycle
- halt_req / resume_req / step_req  in  1 each  debug requests
- write_ir, write_pc, write_pc_ex, write_rd, write_csr, mem_read, mem_write, load_op  out  1 each  datapath strobes
- addr_sel  out  1  0 = PC, 1 = ALU
- rd_sel  out  2  0 = ALU, 1 = MEM, 2 = CSR
- alu_insel1  out  2  0 = RS, 1 = PC, 2 = ZR
- alu_insel2  out  2  0 = RS, 1 = IM, 2 = IS
- beat_idx  out  max(1, log2(BEATS))  current beat number
- halted  out  1  core is in debug halt
- bus_timeout  out  1  one-cycle pulse
- illegal_op  out  1  one-cycle pulse

Function
REQ-005 The states SHALL be FETCH, DISPATCH, MEM, LOAD_WB, STORE_DONE and HALTED.
REQ-006 FETCH: mem_read=1, addr_sel=PC.
- Each mem_complete increments beat_idx.
- write_ir SHALL pulse only on the final beat (beat_idx = BEATS-1).
- Next state is DISPATCH; beat_idx SHALL then return to 0.
REQ-007 DISPATCH decodes opcode in one cycle. LUI, AUIPC, JAL, JALR, OP-IMM and OP assert write_rd=1, rd_sel=ALU and write_pc=1, with these ALU selects:
- LUI: ZR/IM
- AUIPC: PC/IM
- JAL, JALR: PC/IS
- OP-IMM: RS/IM
- OP: RS/RS
REQ-008 BRANCH and MISC-MEM SHALL assert write_pc only.
REQ-009 SYSTEM SHALL assert write_pc. When f3 != 0 it SHALL also assert rd_sel=CSR, write_rd=1 and write_csr=1.
REQ-010 LOAD and STORE SHALL go to MEM with no strobes in the DISPATCH cycle.
REQ-011 MEM: addr_sel=ALU, alu_insel1=RS, alu_insel2=IM, and mem_read=1 (load) or mem_write=1 (store) for each beat.
- Beats advance on mem_complete.
- After the final beat: LOAD_WB for a load, STORE_DONE for a store.
REQ-012 LOAD_WB SHALL assert load_op=1, rd_sel=MEM, write_rd=1 and write_pc=1 for one cycle.
REQ-013 STORE_DONE SHALL assert write_pc=1 for one cycle.
REQ-014 Any undefined opcode in DISPATCH SHALL pulse illegal_op and be handled as an exception.
REQ-015 Exception handling (the exception input, illegal_op or bus_timeout) SHALL, in the same cycle:
- force write_rd, write_csr and mem_write to 0;
- assert write_pc_ex=1;
- leave write_pc = write_pc_ne OR write_pc_ex.
Next state SHALL be FETCH with beat_idx=0.
REQ-016 Timeout: a counter SHALL clear on every mem_complete and on every state change, and increment on each cycle spent in FETCH or MEM without mem_complete.
- When the counter reaches MEM_TIMEOUT, bus_timeout SHALL pulse and REQ-015 applies.
- When MEM_TIMEOUT=0, the counter SHALL never fire.
REQ-017 halt_req SHALL be latched into a pending flag. The flag is honoured only at the instruction boundary: the cycle that would otherwise return to FETCH goes to HALTED instead.
REQ-018 HALTED: all strobes 0, halted=1, and halt_req is ignored.
- resume_req: next state FETCH.
- step_req: next state FETCH, with a re-halt armed for the next instruction boundary.
- resume_req and step_req together: resume wins.
REQ-019 An exception during a step SHALL still return to HALTED after the redirect cycle.
REQ-020 mem_complete arriving in any state other than FETCH or MEM SHALL be ignored.

Reset
REQ-021 While rst=1, the block SHALL be in FETCH with beat_idx=0, the timeout counter 0, and the halt-pending and step flags cleared.
REQ-022 Out of reset, all outputs SHALL be 0 except the FETCH values mem_read=1 and addr_sel=PC.
REQ-023 Reset asserted mid-beat or in HALTED SHALL abandon the operation with no strobe in the following cycle.

Verification
REQ-024 BUS_WIDTH=8, OP opcode, mem_complete every cycle -> write_ir on the 4th fetch cycle, then write_rd, write_pc and ALU selects RS/RS in the 5th cycle.
REQ-025 BUS_WIDTH=16, LOAD with mem_complete delayed 3 cycles per beat -> beat_idx 0 then 1, mem_read held for 8 cycles, then one LOAD_WB cycle with load_op=1 and rd_sel=1.
REQ-026 MEM_TIMEOUT=4, store with mem_complete never asserted -> bus_timeout pulses after 4 MEM cycles, mem_write=0 and write_pc_ex=1 in that cycle, then FETCH.
REQ-027 halt_req mid-LOAD -> the load completes, then halted=1. step_req -> exactly one write_pc, then halted=1 again. resume_req -> FETCH.
REQ-028 Undefined opcode 5'b11111 -> illegal_op=1, write_pc_ex=1, write_rd=0, then FETCH.
REQ-029 rst=1 asserted during the 2nd store beat -> the next cycle shows mem_write=0, FETCH and beat_idx=0.
